dac_spi_tx: RTL
===============

// Module: dac_spi_tx
// PURPOSE
//  Serial transmitter toward the audio DAC. It takes one filtered, pipeline-registered
//  N-bit sample and shifts it out MSB-first as a SYNC/SCLK/DATA frame.
//  It sits after the last pipeline register of the equalizer datapath and is the
//  output-side counterpart of the ADC serial receiver.
//  One frame is sent per start request.
// PARAMETERS
//  N           12  sample width in bits (dato_entrada)
//  FRAME_BITS  16  bits per frame; upper FRAME_BITS-N bits are sent as 0; FRAME_BITS>=N
//  CLK_DIV      2  clk cycles per SCLK half-period; CLK_DIV>=1
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  reset         in   1  synchronous reset, active-high
//  start         in   1  request to send dato_entrada; honoured only in IDLE
//  dato_entrada  in   N  sample to transmit, captured on the accepted start cycle
//  busy          out  1  1 from the cycle after an accepted start through the END cycle
//  done          out  1  one-cycle pulse in the END cycle
//  sync_n        out  1  frame select to DAC, active-low
//  sclk          out  1  serial clock to DAC, idles high
//  sdata         out  1  serial data, MSB first
// BEHAVIOUR
//  Reset:
//   - Synchronous: reset high at a clk edge forces IDLE on the next cycle.
//   - Output values: busy=0, done=0, sync_n=1, sclk=1, sdata=0.
//   - Shift register, bit counter and divider counter are cleared.
//   - Reset mid-frame aborts the frame: no done, idle outputs from the next cycle.
//  FSM states: IDLE -> SHIFT -> END -> IDLE.
//  IDLE:
//   - Outputs are at their idle values.
//   - start=1 at an edge loads shift_reg <= {(FRAME_BITS-N)'b0, dato_entrada}.
//   - The same edge moves the FSM to SHIFT.
//  SHIFT, bit k (k = FRAME_BITS-1 down to 0), lasting 2*CLK_DIV cycles:
//   - sync_n=0, busy=1, sdata=shift_reg[FRAME_BITS-1] (bit k of the frame).
//   - High phase: sclk=1 for CLK_DIV cycles.
//   - Low phase: sclk=0 for CLK_DIV cycles. The DAC samples on the falling sclk edge.
//   - sdata changes only at high-phase starts, never during the low phase.
//   - At the end of the low phase, if k>0: shift left by 1 and start the next high phase.
//   - At the end of the low phase, if k=0: go to END.
//  Frame timing:
//   - sync_n is low for exactly FRAME_BITS*2*CLK_DIV cycles.
//   - The first sclk falling edge comes CLK_DIV cycles after sync_n falls.
//  END (1 cycle):
//   - Outputs: sync_n=1, sclk=1, sdata=0, busy=1, done=1.
//   - The next state is always IDLE.
//  Start handling:
//   - start in SHIFT or END is ignored; it is not queued.
//   - start held high sends back-to-back frames with one END and one IDLE cycle between them.
//  dato_entrada changes after capture do not affect the frame in flight.
//  Counters:
//   - Divider counter is ceil(log2(CLK_DIV)) bits, min 1; it wraps 0..CLK_DIV-1 per half-period.
//   - Bit counter is ceil(log2(FRAME_BITS)) bits.
//   - All outputs are registered; sclk is never a gated clk.
// TESTING (N=12, FRAME_BITS=16, CLK_DIV=2 unless noted)
//  1. Start pulse at cycle 0, dato_entrada=12'hA5C -> sync_n low cycles 1..64;
//     16'h0A5C is sampled on 16 sclk falling edges; done=1 at cycle 65 only; busy=0 at cycle 66.
//  2. dato_entrada=12'hFFF, then 12'h000, then changed mid-frame -> frames 16'h0FFF
//     and 16'h0000; mid-frame changes have no effect.
//  3. start pulsed in SHIFT and again in END -> both ignored; exactly one frame, one done pulse.
//  4. start held high for 3 frames -> 3 identical frames; sync_n high for exactly 2 cycles between frames.
//  5. reset asserted at cycle 30 of a frame -> from cycle 31 sync_n=1, sclk=1, busy=0;
//     no done; the next start sends a full, correct frame.
//  6. CLK_DIV=1, FRAME_BITS=12, dato_entrada=12'h801 -> sclk toggles every cycle;
//     sync_n low 24 cycles; bits 1000_0000_0001 are sampled in order.

Source files
------------

// File: rtl/dac_spi_tx_if.sv
// Handshake and serial-line bundle between the sample pipeline, the DAC transmitter and the DAC pins.
// The slave side is the transmitter; the master side is whoever supplies samples and observes the frame.
interface dac_spi_tx_if #(
  parameter int N = 12
);
  logic         start;
  logic [N-1:0] dato_entrada;
  logic         busy;
  logic         done;
  logic         sync_n;
  logic         sclk;
  logic         sdata;

  modport slave (
    input  start, dato_entrada,
    output busy, done, sync_n, sclk, sdata
  );

  modport master (
    output start, dato_entrada,
    input  busy, done, sync_n, sclk, sdata
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Serial transmitter toward the audio DAC: one zero-padded N-bit sample per start request,
// sent MSB-first as a SYNC/SCLK/DATA frame with every output driven straight from a register.
module dac_spi_tx #(
  parameter int N          = 12,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic           clk,
  input  logic           reset,
  dac_spi_tx_if.slave    io_dac
);

  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_END
  } state_t;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [BW-1:0]         r_bitCnt;
  logic [DW-1:0]         r_divCnt;
  logic                  r_phaseLow;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_syncN;
  logic                  r_sclk;

  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_phaseEnd;

  assign w_frame    = FRAME_BITS'(io_dac.dato_entrada);
  assign w_phaseEnd = (r_divCnt == DIV_LAST);

  // The shift register is zero outside a frame, so its MSB doubles as the registered sdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_divCnt   <= '0;
      r_phaseLow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_syncN    <= 1'b1;
      r_sclk     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (io_dac.start) begin
            r_state    <= ST_SHIFT;
            r_shift    <= w_frame;
            r_bitCnt   <= LAST_BIT;
            r_divCnt   <= '0;
            r_phaseLow <= 1'b0;
            r_busy     <= 1'b1;
            r_syncN    <= 1'b0;
            r_sclk     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!w_phaseEnd) begin
            r_divCnt <= r_divCnt + 1'b1;
          end else begin
            r_divCnt <= '0;
            if (!r_phaseLow) begin
              r_phaseLow <= 1'b1;
              r_sclk     <= 1'b0;
            end else if (r_bitCnt != '0) begin
              // Data moves only here, at the start of a high phase, well away from the falling edge.
              r_phaseLow <= 1'b0;
              r_sclk     <= 1'b1;
              r_shift    <= r_shift << 1;
              r_bitCnt   <= r_bitCnt - 1'b1;
            end else begin
              r_state    <= ST_END;
              r_phaseLow <= 1'b0;
              r_shift    <= '0;
              r_syncN    <= 1'b1;
              r_sclk     <= 1'b1;
              r_done     <= 1'b1;
            end
          end
        end
        ST_END: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_dac.busy   = r_busy;
  assign io_dac.done   = r_done;
  assign io_dac.sync_n = r_syncN;
  assign io_dac.sclk   = r_sclk;
  assign io_dac.sdata  = r_shift[FRAME_BITS-1];

endmodule
